imem_loader: RTL and testbench

- Writer side of the instruction-memory read path: accepts a byte stream from a host link, assembles 16-bit instruction words, and writes them into instruction memory at sequential word addresses.
- Holds the core in reset while loading, checks a length field and a payload checksum, then releases the core.
- Sits beside the core top, between the host byte interface and the instruction memory write port.

---
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: host byte stream -> length-checked, XOR-checksummed 16-bit word writes.
// Latency: a write strobe follows the accepted high byte by one cycle; done/error follow the check byte by one cycle.
// Backpressure: in_ready is high only in byte-receiving states; in_valid low stalls indefinitely.
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-low reset
//   start               one-cycle pulse, honoured only in IDLE/DONE/ERR
//   in_valid/in_ready   byte handshake; in_data carries the byte
//   wr_en/addr/data     one-cycle instruction memory write strobe, word address and word (low byte first on the link)
//   core_hold           holds the core in reset until a load completes with a good checksum
//   done/error          load outcome, held until the next start or reset
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_LO  = 3'd1,
        S_LEN_HI  = 3'd2,
        S_DATA_LO = 3'd3,
        S_DATA_HI = 3'd4,
        S_CHECK   = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } state_t;

    localparam logic [15:0] DEPTH_L = 16'(DEPTH);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] len;
    logic [15:0] count;
    logic [7:0]  csum;
    logic [7:0]  lo_byte;
    logic [15:0] len_full;
    logic        accept;
    logic        load_start;

    assign accept   = in_valid && in_ready;
    // Full length as seen while the high byte is being accepted.
    assign len_full = {in_data, len[7:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        load_start = 1'b0;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    load_start = 1'b1;
                    state_nxt  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (accept) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (len_full > DEPTH_L)      state_nxt = S_ERR;
                    else if (len_full == 16'd0)  state_nxt = S_CHECK;
                    else                         state_nxt = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                in_ready = 1'b1;
                if (accept) state_nxt = S_DATA_HI;
            end
            S_DATA_HI: begin
                in_ready = 1'b1;
                // count has not yet been bumped for this word; that happens when its strobe drops.
                if (accept) state_nxt = (count + 16'd1 == len) ? S_CHECK : S_DATA_LO;
            end
            S_CHECK: begin
                in_ready = 1'b1;
                if (accept) state_nxt = (in_data == csum) ? S_DONE : S_ERR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign core_hold = (state != S_DONE);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            len     <= '0;
            count   <= '0;
            csum    <= '0;
            lo_byte <= '0;
        end else begin
            wr_en <= 1'b0;
            if (wr_en) count <= count + 16'd1;

            if (load_start) begin
                count   <= '0;
                csum    <= '0;
                len     <= '0;
                wr_addr <= '0;
            end

            if (accept) begin
                unique case (state)
                    S_LEN_LO: len[7:0]  <= in_data;
                    S_LEN_HI: len[15:8] <= in_data;
                    S_DATA_LO: begin
                        lo_byte <= in_data;
                        csum    <= csum ^ in_data;
                    end
                    S_DATA_HI: begin
                        wr_en   <= 1'b1;
                        wr_data <= {in_data, lo_byte};
                        wr_addr <= count[ADDR_W-1:0];
                        csum    <= csum ^ in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        core_hold;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t wq[$];
    int  wr_dup = 0;
    logic prev_we = 1'b0;

    // Nominal image: 3 words, low byte first.
    logic [7:0]  payload [6] = '{8'h13, 8'h05, 8'h93, 8'h00, 8'h33, 8'h81};
    logic [15:0] exp_word [3] = '{16'h0513, 16'h0093, 16'h8133};
    logic [7:0]  good_chk;

    imem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_hold(core_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Capture writes away from the active edge; flag any strobe longer than one cycle.
    always @(negedge clk) begin
        if (rst && wr_en) wq.push_back('{a: wr_addr, d: wr_data});
        if (rst && wr_en && prev_we) wr_dup++;
        prev_we = rst && wr_en;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Offer one byte; returns just after the edge that transferred it.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 64; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1 in_valid = 1'b0;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) check("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic gap(input int max_gap);
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    endtask

    task automatic run_load(input logic [7:0] chk, input int max_gap, input bit ignored_start);
        wq.delete();
        wr_dup = 0;
        pulse_start();
        send_byte(8'h03);
        gap(max_gap);
        send_byte(8'h00);
        if (ignored_start) begin
            // Loader sits in DATA_LO here; a start must not disturb it.
            pulse_start();
            check("ign_start_ready", in_ready, 1'b1);
            check("ign_start_hold", core_hold, 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            gap(max_gap);
            send_byte(payload[i]);
        end
        gap(max_gap);
        send_byte(chk);
    endtask

    task automatic check_writes(input string tag, input int n);
        check({tag, "_nwr"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            check({tag, "_addr"}, wq[i].a, i);
            check({tag, "_data"}, wq[i].d, exp_word[i]);
        end
        check({tag, "_strobe1"}, wr_dup, 0);
    endtask

    initial begin
        good_chk = 8'h00;
        for (int i = 0; i < 6; i++) good_chk = good_chk ^ payload[i];

        // Reset values
        #7;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_addr", wr_addr, 8'h00);
        check("rst_wr_data", wr_data, 16'h0000);
        check("rst_core_hold", core_hold, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", in_ready, 1'b0);

        // Nominal back-to-back load
        run_load(good_chk, 0, 1'b0);
        repeat (3) @(negedge clk);
        check_writes("nom", 3);
        check("nom_done", done, 1'b1);
        check("nom_hold", core_hold, 1'b0);
        check("nom_error", error, 1'b0);
        check("nom_ready", in_ready, 1'b0);

        // Restart from DONE
        pulse_start();
        check("rs_done", done, 1'b0);
        check("rs_hold", core_hold, 1'b1);
        check("rs_ready", in_ready, 1'b1);
        // Finish this load with a bad checksum (restart path already consumed the start)
        wq.delete();
        wr_dup = 0;
        send_byte(8'h03);
        send_byte(8'h00);
        for (int i = 0; i < 6; i++) send_byte(payload[i]);
        send_byte(good_chk ^ 8'h3B);
        repeat (3) @(negedge clk);
        check_writes("bad", 3);
        check("bad_error", error, 1'b1);
        check("bad_hold", core_hold, 1'b1);
        check("bad_done", done, 1'b0);

        // Oversize length 257 from ERR
        wq.delete();
        pulse_start();
        check("ovs_error_clr", error, 1'b0);
        send_byte(8'h01);
        send_byte(8'h01);
        check("ovs_error", error, 1'b1);
        check("ovs_ready", in_ready, 1'b0);
        repeat (3) @(negedge clk);
        check("ovs_nwr", wq.size(), 0);
        check("ovs_hold", core_hold, 1'b1);

        // Zero length: checksum of nothing is zero
        wq.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (2) @(negedge clk);
        check("zero_nwr", wq.size(), 0);
        check("zero_done", done, 1'b1);
        check("zero_hold", core_hold, 1'b0);

        // Stalled handshake plus an ignored start in DATA_LO
        run_load(good_chk, 3, 1'b1);
        repeat (3) @(negedge clk);
        check_writes("stall", 3);
        check("stall_done", done, 1'b1);
        check("stall_error", error, 1'b0);

        // Reset right after the 2nd word's high byte
        wq.delete();
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(payload[i]);
        rst = 1'b0;
        #1;
        check("mid_wr_en", wr_en, 1'b0);
        check("mid_wr_addr", wr_addr, 8'h00);
        check("mid_hold", core_hold, 1'b1);
        check("mid_ready", in_ready, 1'b0);
        check("mid_done", done, 1'b0);
        check("mid_error", error, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        run_load(good_chk, 1, 1'b0);
        repeat (3) @(negedge clk);
        check_writes("after_rst", 3);
        check("after_rst_done", done, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
